draw_card: RTL and testbench
============================

# draw_card

Card-draw unit for the 21 card game: a free-running card source that latches a card value (1..13) on each rising edge of a draw request. It also drives two active-low seven-segment digits showing that value in decimal. It sits between the game control/datapath and the board HEX displays. The datapath consumes `card`; `tens`/`ones` go straight to a HEX pair.

## Interface
- No parameters; constants live in the shared package.
- `clock`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  1  draw request, level input; only its 0->1 transition is acted on.
- `card`  out  4  latched card value; 0 means no card drawn since reset, otherwise 1..13.
- `tens`  out  7  seven-segment tens digit of `card`, active-low, bit0=a .. bit6=g.
- `ones`  out  7  seven-segment ones digit of `card`, active-low, bit0=a .. bit6=g.

## Operation
- Source register `src` (4 bits) is the card source.
  - Counts 1,2,...,13,1,... and advances on every clock edge, regardless of `in`.
  - Values 0, 14 and 15 never appear. If `src` is ever found out of range, it loads 1 on the next edge.
- Edge detect: register `in_d` holds the previous-cycle value of `in`.
  - Draw event = `in`==1 and `in_d`==0, both sampled at the same clock edge.
- On a draw event, `card` <= current `src` value (the value before that edge's increment).
- `card` holds its value between draw events. Holding `in` high for any number of cycles yields exactly one draw.
- Display decode is combinational from `card`:
  - ones = `card` mod 10; tens = `card` / 10.
  - tens shows blank (7'b1111111) when `card` < 10, i.e. leading-zero suppression.
  - ones always shows a digit; with `card`=0 it shows "0".
- Digit encodings, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset (`reset`=0, asynchronous): `src`=1, `in_d`=0, `card`=0, `tens`=blank, `ones`="0".
- Reset deassertion is synchronous to `clock`. `src` first advances on the first edge with `reset`=1.
- Latency: `card` updates on the same edge that detects the draw. `tens`/`ones` follow combinationally in that same cycle.
- If `in` is already 1 at reset release, that counts as a rising edge, because `in_d` resets to 0. One draw occurs on the first edge.
- If reset is asserted mid-draw, it wins immediately: `card` returns to 0.
- A new rising edge needs `in` low for at least one sampled edge in between.

## Configuration
- `DRAW_CARD_LFSR_EN`
  - Defined: the source is an 8-bit maximal-length Galois LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'h01. It steps every clock.
  - Defined: on a draw, `card` <= (lfsr mod 13) + 1. The LFSR never reaches zero.
  - Undefined: the mod-13 counter described above is used.
- All other behaviour is identical with or without the macro.

## Structure
- Shared package `card_pkg` holds:
  - `CARD_MIN`=1, `CARD_MAX`=13
  - `SEG_BLANK`=7'b1111111
  - the 16-entry segment encoding constants
- Sub-module `hex_display`: 4-bit value -> 7-bit active-low segments, purely combinational, full 0..F coverage. It is instantiated twice (tens, ones).
- The tens digit of a blank is selected in `draw_card`, not inside `hex_display`.

## Test plan
- Assert `reset`=0, then release: `card`=0, `tens`=1111111, `ones`=1000000. After 13 edges `src` is back at 1 (counter build).
- Raise `in` at the edge where `src`=5: `card`=5, `ones`=0010010, `tens` blank. Hold `in` high 40 cycles: `card` stays 5.
- Draw at `src`=12: `card`=12, `tens`=1111001, `ones`=0100100. Draw at `src`=13 after a low cycle: `card`=13, `ones`=0110000.
- Counter wrap: after `src`=13, the next value is 1. A draw at that edge gives `card`=1.
- Assert `reset`=0 asynchronously mid-cycle while `card`=9: `card`=0 immediately, with no clock edge needed. Release with `in`=1: one draw on the first edge.
- `DRAW_CARD_LFSR_EN` build: 300 draws all give `card` in 1..13. The LFSR sequence has period 255 and never reaches 0.

Source files
------------

// File: rtl/card_pkg.sv
// ============================================================================
// Package     : card_pkg
// Description : Shared constants for the draw_card unit: card range, blank
//               digit code and the 16 active-low seven-segment encodings
//               (bit0 = a .. bit6 = g). The LFSR seed/taps exist only when
//               DRAW_CARD_LFSR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package card_pkg;

  localparam logic [3:0] CARD_MIN  = 4'd1;
  localparam logic [3:0] CARD_MAX  = 4'd13;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

`ifdef DRAW_CARD_LFSR_EN
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
`endif

endpackage

`default_nettype wire

// File: rtl/draw_card_if.sv
// ============================================================================
// Interface   : draw_card_if
// Description : Draw request plus card value and HEX digit pair.
//   in    draw request (level, rising edge acted on)
//   card  latched card value, 0 = none drawn
//   tens  active-low tens digit segments
//   ones  active-low ones digit segments
// Modports    : master (game side), slave (draw_card)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface draw_card_if;
  logic       in;
  logic [3:0] card;
  logic [6:0] tens;
  logic [6:0] ones;

  modport master (output in, input card, input tens, input ones);
  modport slave  (input in, output card, output tens, output ones);
endinterface

`default_nettype wire

// File: rtl/hex_display.sv
// ============================================================================
// Module      : hex_display
// Description : Combinational 4-bit value to active-low seven-segment decode,
//               full 0..F coverage.
//   value  in  4  hex value
//   seg    out 7  active-low segments, bit0 = a .. bit6 = g
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display
  import card_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/draw_card.sv
// ============================================================================
// Module      : draw_card
// Description : Free-running card source; latches a card (1..13) on each
//               rising edge of the draw request and shows it in decimal on
//               two active-low seven-segment digits.
//   clock  in  1  system clock
//   reset  in  1  asynchronous active-low reset
//   bus    draw_card_if.slave (in / card / tens / ones)
// Config      : DRAW_CARD_LFSR_EN - source is an 8-bit Galois LFSR and the
//               card is (lfsr mod 13) + 1; otherwise a 1..13 counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_card
  import card_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  draw_card_if.slave bus
);

  logic [3:0] draw_val;
  logic       in_d;
  logic [3:0] card_reg;

`ifdef DRAW_CARD_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 8'h00) begin
      // Lock-up state is unreachable from the seed; recover anyway.
      lfsr <= LFSR_SEED;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  assign draw_val = 4'(lfsr % {4'd0, CARD_MAX}) + CARD_MIN;
`else
  logic [3:0] src;

  // 13 wraps to 1 through the same branch that repairs 0/14/15.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src <= CARD_MIN;
    end else if (src < CARD_MIN || src >= CARD_MAX) begin
      src <= CARD_MIN;
    end else begin
      src <= src + 4'd1;
    end
  end

  assign draw_val = src;
`endif

  // in_d resets low, so a request already high at reset release draws once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_d     <= 1'b0;
      card_reg <= 4'd0;
    end else begin
      in_d <= bus.in;
      if (bus.in && !in_d) begin
        card_reg <= draw_val;
      end
    end
  end

  // Decimal split of a 0..15 value: at most one tens digit.
  logic       two_digit;
  logic [3:0] tens_val;
  logic [3:0] ones_val;
  logic [6:0] tens_seg;
  logic [6:0] ones_seg;

  assign two_digit = (card_reg >= 4'd10);
  assign tens_val  = two_digit ? 4'd1 : 4'd0;
  assign ones_val  = two_digit ? (card_reg - 4'd10) : card_reg;

  hex_display u_tens (
    .value (tens_val),
    .seg   (tens_seg)
  );

  hex_display u_ones (
    .value (ones_val),
    .seg   (ones_seg)
  );

  assign bus.card = card_reg;
  assign bus.tens = two_digit ? tens_seg : SEG_BLANK;
  assign bus.ones = ones_seg;

endmodule

`default_nettype wire

// File: tb/tb_draw_card.sv
// ============================================================================
// Module      : tb_draw_card
// Description : Self-checking bench for draw_card. A reference model derives
//               the source value from the number of edges since reset release
//               and predicts card/tens/ones after every edge.
// Config      : honours DRAW_CARD_LFSR_EN for the reference source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_card;

  logic clock;
  logic reset;

  draw_card_if bus ();

  draw_card dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed;
  int total;

  // Reference model state
  int   k;        // edges since reset release
  logic prev_in;
  int   m_card;
  logic [6:0] digit_seg [10];
  int   lfsr_seq [255];

  function automatic int draw_value(input int edges);
`ifdef DRAW_CARD_LFSR_EN
    return (lfsr_seq[edges % 255] % 13) + 1;
`else
    return (edges % 13) + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [6:0] exp_tens;
    logic [6:0] exp_ones;
    exp_tens = (m_card < 10) ? 7'b1111111 : digit_seg[m_card / 10];
    exp_ones = digit_seg[m_card % 10];
    check({tag, ".card"}, {28'd0, bus.card}, m_card);
    check({tag, ".tens"}, {25'd0, bus.tens}, {25'd0, exp_tens});
    check({tag, ".ones"}, {25'd0, bus.ones}, {25'd0, exp_ones});
  endtask

  // One clock edge, model update, then sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      if (bus.in && !prev_in) m_card = draw_value(k);
      prev_in = bus.in;
      k++;
    end
    #1;
  endtask

  // Idle with in low until the next edge would draw the target value.
  task automatic advance_to(input int target);
    int n;
    n = 0;
    bus.in = 1'b0;
    tick();
    while (draw_value(k) != target && n < 300) begin
      tick();
      n++;
    end
    check("advance_bound", (n < 300) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic draw_at(input int target, input string tag);
    advance_to(target);
    bus.in = 1'b1;
    tick();
    check_all(tag);
    check({tag, ".value"}, {28'd0, bus.card}, target);
  endtask

  initial begin
    int x;
    digit_seg[0] = 7'b1000000; digit_seg[1] = 7'b1111001;
    digit_seg[2] = 7'b0100100; digit_seg[3] = 7'b0110000;
    digit_seg[4] = 7'b0011001; digit_seg[5] = 7'b0010010;
    digit_seg[6] = 7'b0000010; digit_seg[7] = 7'b1111000;
    digit_seg[8] = 7'b0000000; digit_seg[9] = 7'b0010000;
    // LFSR state sequence from the polynomial, multiply-by-x^-1 form.
    x = 1;
    for (int i = 0; i < 255; i++) begin
      lfsr_seq[i] = x;
      x = (x % 2 == 1) ? ((x / 2) ^ 184) : (x / 2);
    end

    passed  = 0;
    total   = 0;
    k       = 0;
    prev_in = 1'b0;
    m_card  = 0;
    bus.in  = 1'b0;
    reset   = 1'b1;

    // Reset and release
    #2 reset = 1'b0;
    repeat (3) tick();
    check_all("reset");
    #3 reset = 1'b1;
    k = 0; prev_in = 1'b0; m_card = 0;
    #1;
    check_all("post_release");

    // 13 idle edges, then draw: source has come back round to its start.
    repeat (13) tick();
    check_all("idle13");
    bus.in = 1'b1;
    tick();
    check_all("after13");
    check("after13.value", {28'd0, bus.card}, draw_value(13));

    // Draw 5 and hold high for 40 cycles
    draw_at(5, "draw5");
    repeat (40) tick();
    check_all("hold40");
    check("hold40.value", {28'd0, bus.card}, 32'd5);

    draw_at(12, "draw12");
    draw_at(13, "draw13");

    // Wrap: draw on the edge right after a 13
    advance_to(13);
    tick();
    bus.in = 1'b1;
    tick();
    check_all("wrap");
`ifndef DRAW_CARD_LFSR_EN
    check("wrap.value", {28'd0, bus.card}, 32'd1);
`endif

    // Randomized request pattern
    for (int i = 0; i < 300; i++) begin
      bus.in = 1'($urandom_range(0, 1));
      tick();
      check_all("random");
      if (m_card != 0)
        check("random.range", (bus.card >= 4'd1 && bus.card <= 4'd13) ? 32'd1 : 32'd0, 32'd1);
    end

    // Async reset mid-cycle with card = 9
    draw_at(9, "draw9");
    #3 reset = 1'b0;
    k = 0; prev_in = 1'b0; m_card = 0;
    #1;
    check_all("async_reset");
    bus.in = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_all("release_in_high");
    check("release_in_high.value", {28'd0, bus.card}, draw_value(0));
    repeat (3) tick();
    check_all("release_hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
